mdu_iter: RTL and testbench

- Parametrised successor to the fixed-latency HI/LO multiply/divide unit.
- Sits in the EX stage beside the ALU and implements MULT/MULTU/DIV/DIVU with a genuine iterative datapath: shift-add multiply and restoring divide, one bit per cycle.
- Adds a pipeline-flush cancel and an exact, data-independent latency of WIDTH+1 busy cycles.
- The stall unit watches busy; MFHI/MFLO read hi/lo directly.

---
 rtl/mdu_iter.sv | 122 ++++++++++++
 tb/tb_mdu_iter.sv | 110 +++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide, WIDTH+1 busy cycles); ports clk, reset, start/op/a/b issue, cancel flush, busy/done status, hi/lo results; define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [3:0] op_q, op_d;
  logic sign_a_q, sign_a_d, sign_b_q, sign_b_d, done_q, done_d;
  logic md_in, sgn_in, is_div, issue;
  logic [WIDTH:0] psum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod_fix, mul_res;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign sgn_in = op == 4'd0 || op == 4'd1 || op == 4'd6 || op == 4'd8;
`ifdef MDU_MADD_EN
  assign md_in = op <= 4'd3 || (op >= 4'd6 && op <= 4'd9);
`else
  assign md_in = op <= 4'd3;
`endif
  assign issue = state_q == IDLE && start && !cancel;
  assign is_div = op_q == 4'd1 || op_q == 4'd3;
  assign sign_a_d = issue && md_in ? sgn_in & a[WIDTH-1] : sign_a_q;
  assign sign_b_d = issue && md_in ? sgn_in & b[WIDTH-1] : sign_b_q;
  // Multiply step: add multiplicand on multiplier LSB, shift the 2W product right.
  assign psum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
  // Divide step: remainder lives in acc high half, quotient shifts into the low half.
  assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
  assign diff = rem_sh - {1'b0, opb_q};
  assign prod_fix = sign_a_q ^ sign_b_q ? -acc_q : acc_q;
  assign quo_fix = sign_a_q ^ sign_b_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`ifdef MDU_MADD_EN
  assign mul_res = op_q >= 4'd8 ? {hi_q, lo_q} - prod_fix :
                   op_q >= 4'd6 ? {hi_q, lo_q} + prod_fix : prod_fix;
`else
  assign mul_res = prod_fix;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (cancel) state_d = IDLE;
    else if (issue && md_in) state_d = CALC;
    else if (state_q == CALC && cnt_q == CNT_W'(1)) state_d = FIX;
    else if (state_q == FIX) state_d = IDLE;
  end
  always_comb begin
    cnt_d  = cnt_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    acc_d  = acc_q;
    op_d   = op_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (issue && md_in) begin
      opa_d = sign_a_d ? -a : a;
      opb_d = sign_b_d ? -b : b;
      op_d  = op;
      acc_d = '0;
      cnt_d = CNT_W'(WIDTH);
    end else if (issue) begin
      hi_d = op == 4'd4 ? a : hi_q;
      lo_d = op == 4'd5 ? a : lo_q;
    end else if (state_q == CALC && !cancel) begin
      cnt_d = cnt_q - CNT_W'(1);
      acc_d = is_div ? {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], !diff[WIDTH]}
                     : {psum, acc_q[WIDTH-1:1]};
      opa_d = is_div ? opa_q << 1 : opa_q;
      opb_d = is_div ? opb_q : opb_q >> 1;
    end else if (state_q == FIX && !cancel) begin
      {hi_d, lo_d} = is_div ? {rem_fix, quo_fix} : mul_res;
      done_d = 1'b1;
    end
  end
  always_comb begin
    busy = state_q != IDLE;
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter at WIDTH=32
module tb_mdu_iter;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cancel = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  logic [63:0] sb_q[$];
  int total = 0, passed = 0, done_cnt = 0;
  mdu_iter dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  always @(negedge clk) if (done) begin
    done_cnt++;
    if (sb_q.size() == 0) check("spurious_done", 64'd1, 64'd0);
    else check("result", {hi, lo}, sb_q.pop_front());
  end
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
    int n = 0;
    int d0 = done_cnt;
    sb_q.push_back(exp);
    issue(o, x, y);
    while (busy && n < 100) begin n++; @(negedge clk); end
    check("busy_cycles", 64'(n), 64'd33);
    @(negedge clk);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask
  initial begin
    logic [63:0] held;
    int d0, n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {28'd0, busy, done, hi, lo}, 64'd0);
    run(4'd0, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    run(4'd1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run(4'd3, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
    issue(4'd4, 32'hDEADBEEF, 32'd0);
    check("mthi_hi", 64'(hi), 64'hDEADBEEF);
    check("mthi_busy", 64'(busy), 64'd0);
    sb_q.push_back(64'h00000003_00030000);
    issue(4'd2, 32'h00010000, 32'h00030003);
    repeat (3) @(negedge clk);
    issue(4'd5, 32'd1, 32'd0);
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    @(negedge clk);
    check("mtlo_ignored", {hi, lo}, 64'h00000003_00030000);
    held = {hi, lo};
    d0 = done_cnt;
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("cancel_hilo", {hi, lo}, held);
    check("cancel_no_done", 64'(done_cnt - d0), 64'd0);
    op = 4'd0; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel", 64'(busy), 64'd0);
    run(4'd1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] x, y;
      int q, r;
      x = $urandom;
      y = $urandom;
      run(4'd0, x, y, 64'(longint'($signed(x)) * longint'($signed(y))));
      run(4'd2, x, y, 64'(x) * 64'(y));
      y = $urandom_range(1, 1000);
      if (i % 2 == 1) y = -y;
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
      run(4'd1, x, y, {32'(r), 32'(q)});
      run(4'd3, x, y, {x % y, x / y});
    end
    issue(4'd1, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset", {28'd0, busy, done, hi, lo}, 64'd0);
    issue(4'd5, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    run(4'd7, 32'd1, 32'd1, 64'h00000001_00000000);
    run(4'd8, 32'd2, 32'hFFFFFFFD, 64'h00000001_00000006);
`else
    d0 = done_cnt;
    issue(4'd7, 32'd1, 32'd1);
    check("maddu_nop_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("maddu_nop_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
    check("maddu_nop_done", 64'(done_cnt - d0), 64'd0);
`endif
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
